divu_seq: RTL and testbench

Sequential unsigned 32-bit divider for the DIVU operation (Signal 27). It accepts a dividend/divisor pair on a start pulse and runs one restoring-division step per clock. It then presents a 64-bit {remainder, quotient} result with a one-cycle done pulse. The result feeds the HiLo register's 64-bit input alongside the multiplier product: Hi receives the remainder and Lo receives the quotient.

---
 rtl/divu_seq.sv | 95 +++++++++
 tb/tb_divu_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/divu_seq.sv
// Sequential unsigned divider: one restoring-division step per clock, WIDTH steps per result.
// Produces {remainder, quotient} with a one-cycle done pulse; divisor 0 runs the same datapath.
module divu_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  output logic                 busy,
  output logic                 done,
  output logic                 divZero,
  output logic [2*WIDTH-1:0]   divAns,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] quo_nx;

  assign dbg_state = state;

  // The quotient register doubles as the dividend shift register: its MSB feeds the remainder.
  always_comb begin
    rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
    trial  = rem_sh - {1'b0, divisor};
    rem_nx = rem_sh;
    quo_nx = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_nx = trial;
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divZero <= 1'b0;
      divAns  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            quo     <= dataA;
            divisor <= dataB;
            rem     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            divAns  <= {rem_nx[WIDTH-1:0], quo_nx};
            divZero <= (divisor == '0);
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divu_seq.sv
// Self-checking bench for divu_seq: vector table plus hand-built busy/reset/operand-change sequences.
`timescale 1ns/1ps
module tb_divu_seq;

  localparam int W = 32;
  localparam int LAT = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  dataA = '0;
  logic [W-1:0]  dataB = '0;
  logic          busy, done, divZero;
  logic [2*W-1:0] divAns;
  logic [1:0]    dbg_state;

  divu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .dataA(dataA), .dataB(dataB),
    .busy(busy), .done(done), .divZero(divZero), .divAns(divAns), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] ans;
    logic           zero;
  } vec_t;

  logic [2*W:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives a one-cycle start pulse; returns at the negedge after the start edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    logic [W-1:0] q;
    logic [W-1:0] r;
    @(negedge clk);
    dataA = a;
    dataB = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    if (push) begin
      q = (b == 0) ? '1 : a / b;
      r = (b == 0) ? a : a % b;
      exp_q.push_back({(b == 0), r, q});
    end
  endtask

  task automatic collect(input bit scramble);
    logic [2*W:0]   e;
    logic [2*W-1:0] held;
    bit got;
    bit changed;
    got = 1'b0;
    changed = 1'b0;
    held = divAns;
    while (!got && (cyc - t0) <= LAT + 8) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else if (scramble) begin
        if (divAns !== held) changed = 1'b1;
        dataA = $urandom;
        dataB = $urandom;
      end
    end
    if (scramble) chk("divans_stable_in_run", {63'd0, changed}, 64'd0);
    if (!got) begin
      chk("done_timeout", 64'd0, 64'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    chk("latency", 64'(cyc - t0), 64'(LAT));
    chk("busy_in_done", {63'd0, busy}, 64'd1);
    if (exp_q.size() == 0) begin
      chk("unexpected_done", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("divans", divAns, e[2*W-1:0]);
      chk("divzero", {63'd0, divZero}, {63'd0, e[2*W]});
    end
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    vec_t vecs[9];
    int dc;
    vecs[0] = '{32'd100, 32'd7, 64'h00000002_0000000E, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 1'b0};
    vecs[2] = '{32'd3, 32'd10, 64'h00000003_00000000, 1'b0};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0};
    vecs[4] = '{32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1};
    vecs[5] = '{32'd0, 32'd9, 64'h00000000_00000000, 1'b0};
    vecs[6] = '{32'h80000000, 32'h80000001, 64'h80000000_00000000, 1'b0};
    vecs[7] = '{32'd1000000, 32'd1000, 64'h00000000_000003E8, 1'b0};
    vecs[8] = '{32'hDEADBEEF, 32'd0, 64'hDEADBEEF_FFFFFFFF, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_divzero", {63'd0, divZero}, 64'd0);
    chk("reset_divans", divAns, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({vecs[i].zero, vecs[i].ans});
      launch(vecs[i].a, vecs[i].b, 1'b0);
      chk("busy_after_start", {63'd0, busy}, 64'd1);
      collect(1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      launch($urandom, (i == 5) ? 32'd0 : 32'($urandom_range(1, 100000)), 1'b1);
      collect(1'b0);
    end

    // start pulses while busy (mid-RUN and in DONE) must be ignored
    dc = done_cnt;
    launch(32'd100, 32'd7, 1'b1);
    repeat (4) @(negedge clk);
    dataA = 32'd9; dataB = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && (cyc - t0) < LAT + 8) @(negedge clk);
    dataA = 32'd9; dataB = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_ignored_state", {62'd0, dbg_state}, 64'd0);
    repeat (LAT + 6) @(negedge clk);
    chk("busy_start_done_count", 64'(done_cnt - dc), 64'd1);
    chk("busy_start_result", divAns, 64'h00000002_0000000E);
    void'(exp_q.pop_front());
    launch(32'd9, 32'd3, 1'b1);
    collect(1'b0);

    // reset mid-RUN discards the division
    launch(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_divans", divAns, 64'd0);
    chk("midrst_state", {62'd0, dbg_state}, 64'd0);
    dc = done_cnt;
    repeat (LAT + 6) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt - dc), 64'd0);
    launch(32'd20, 32'd6, 1'b1);
    collect(1'b0);

    // reset wins over a simultaneous start
    @(negedge clk);
    reset = 1'b1; start = 1'b1; dataA = 32'd50; dataB = 32'd5;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", {63'd0, busy}, 64'd0);

    // operand changes during RUN, with a prior result held on divAns
    launch(32'd81, 32'd9, 1'b1);
    collect(1'b0);
    launch(32'd100, 32'd7, 1'b1);
    collect(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
